// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI4 read-channel arbiter, one burst in flight at a time.
// Round-robin grant is held from AR acceptance until the RLAST beat.
module axi_rd_arbiter #(
    parameter int ID_WIDTH   = 6,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2*ID_WIDTH-1:0]   s_arid,
    input  logic [2*ADDR_WIDTH-1:0] s_araddr,
    input  logic [15:0]             s_arlen,
    input  logic [1:0]              s_arvalid,
    output logic [1:0]              s_arready,
    output logic [2*ID_WIDTH-1:0]   s_rid,
    output logic [2*DATA_WIDTH-1:0] s_rdata,
    output logic [3:0]              s_rresp,
    output logic [1:0]              s_rlast,
    output logic [1:0]              s_rvalid,
    input  logic [1:0]              s_rready,
    output logic [ID_WIDTH-1:0]     m_arid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    output logic                    grant,
    output logic                    busy,
    output logic                    err_len
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic [7:0]            beats_q, beats_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic                  err_len_q, err_len_d;
    logic                  busy_q, busy_d;

    logic [ID_WIDTH-1:0]   sel_id;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [7:0]            sel_len;
    logic                  sel_arvalid;
    logic                  beat;

    // Request fields of the currently granted requester.
    always_comb begin
        sel_id      = grant_q ? s_arid[ID_WIDTH +: ID_WIDTH]       : s_arid[0 +: ID_WIDTH];
        sel_addr    = grant_q ? s_araddr[ADDR_WIDTH +: ADDR_WIDTH] : s_araddr[0 +: ADDR_WIDTH];
        sel_len     = grant_q ? s_arlen[8 +: 8]                    : s_arlen[0 +: 8];
        sel_arvalid = s_arvalid[grant_q];
    end

    // Handshake routing, decoded from state so IDLE never passes s_* to m_*.
    always_comb begin
        m_arvalid = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arlen   = '0;
        s_arready = 2'b00;
        m_rready  = 1'b0;
        s_rvalid  = 2'b00;
        if (state_q == ADDR) begin
            m_arvalid          = sel_arvalid;
            m_arid             = sel_id;
            m_araddr           = sel_addr;
            m_arlen            = sel_len;
            s_arready[grant_q] = m_arready;
        end
        if (state_q == DATA) begin
            m_rready          = s_rready[grant_q];
            s_rvalid[grant_q] = m_rvalid;
        end
    end

    assign m_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_arburst = 2'b01;
    assign s_rdata   = {2{m_rdata}};
    assign s_rresp   = {2{m_rresp}};
    assign s_rlast   = {2{m_rlast}};
    assign s_rid     = {2{id_q}};
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign err_len   = err_len_q;
    assign beat      = m_rvalid & m_rready;

    // Next-state: round-robin pick in IDLE, capture on AR, count beats in DATA.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        beats_d   = beats_q;
        id_d      = id_q;
        err_len_d = err_len_q;
        case (state_q)
            IDLE: begin
                if (|s_arvalid) begin
                    // Both pending: take the one not served last time.
                    grant_d = (&s_arvalid) ? ~last_q : s_arvalid[1];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                if (m_arvalid && m_arready) begin
                    beats_d = sel_len;
                    id_d    = sel_id;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (beat) begin
                    beats_d = beats_q - 8'd1;
                    // RLAST must coincide with the final counted beat.
                    if (m_rlast != (beats_q == 8'd0))
                        err_len_d = 1'b1;
                    if (m_rlast) begin
                        state_d = IDLE;
                        last_d  = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State registers with synchronous reset; a burst in flight is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            beats_q   <= '0;
            id_q      <= '0;
            err_len_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            beats_q   <= beats_d;
            id_q      <= id_d;
            err_len_q <= err_len_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- 2:1 AXI4 read-channel arbiter. Merges the pixel read master (port 0) and the weights read master (port 1) onto one AXI4 read slave, e.g. a single axi2ram read port or a single shared DDR read port.
- Non-interleaved: exactly one burst is in flight at a time, and the grant is held from AR acceptance until the RLAST beat.
- Arbitration is round-robin.
- Sits between the engine's read DMAs and the memory-side slave in the testbench and SoC top.

Parameters:
- ID_WIDTH, 6, AXI ID width.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 128, AXI data width; power of two, ≥ 8.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- s_arid  in  2*ID_WIDTH  per-requester ARID; requester i occupies bits [i*ID_WIDTH +: ID_WIDTH] (same packing for all s_ buses).
- s_araddr  in  2*ADDR_WIDTH  per-requester ARADDR.
- s_arlen  in  16  per-requester ARLEN, 8 bits each.
- s_arvalid  in  2  per-requester ARVALID.
- s_arready  out  2  per-requester ARREADY.
- s_rid  out  2*ID_WIDTH  per-requester RID.
- s_rdata  out  2*DATA_WIDTH  per-requester RDATA.
- s_rresp  out  4  per-requester RRESP.
- s_rlast  out  2  per-requester RLAST.
- s_rvalid  out  2  per-requester RVALID.
- s_rready  in  2  per-requester RREADY.
- m_arid  out  ID_WIDTH  slave ARID.
- m_araddr  out  ADDR_WIDTH  slave ARADDR.
- m_arlen  out  8  slave ARLEN.
- m_arsize  out  3  constant $clog2(DATA_WIDTH/8).
- m_arburst  out  2  constant 2'b01 (INCR).
- m_arvalid  out  1  slave ARVALID.
- m_arready  in  1  slave ARREADY.
- m_rdata  in  DATA_WIDTH  slave RDATA.
- m_rresp  in  2  slave RRESP.
- m_rlast  in  1  slave RLAST.
- m_rvalid  in  1  slave RVALID.
- m_rready  out  1  slave RREADY.
- grant  out  1  index of the current or last granted requester.
- busy  out  1  high in ADDR and DATA states.
- err_len  out  1  sticky burst-length error flag.

Behaviour:
- FSM states: IDLE, ADDR, DATA. Registers: grant, last (round-robin pointer), beats (8 b), id_q.
- Reset (rst=1 at posedge, including mid-burst):
  - state=IDLE, grant=0, last=1, beats=0, err_len=0.
  - Every m_/s_ valid and ready output is low in the cycle after reset, i.e. it is driven combinationally from state.
  - An in-flight burst is abandoned. The slave is assumed to be reset by the same rst.
- IDLE:
  - All handshake outputs are 0.
  - If |s_arvalid: if both are valid, grant <= ~last; otherwise grant <= the index of the single valid bit. Then → ADDR.
  - Request-to-m_arvalid latency is 1 cycle.
- ADDR:
  - m_arvalid = s_arvalid[grant]; m_arid/araddr/arlen = s_ fields[grant]; s_arready[grant] = m_arready; the other s_arready is 0.
  - On m_arvalid & m_arready: beats <= arlen, id_q <= arid, → DATA.
  - A requester dropping ARVALID before handshake (an AXI violation) does not release the grant.
- DATA:
  - s_rvalid[grant] = m_rvalid; m_rready = s_rready[grant]; the other s_rvalid is 0.
  - s_rdata, s_rresp and s_rlast are broadcast to both slots; s_rid for both slots = id_q.
  - Each beat (m_rvalid & m_rready): beats <= beats - 1. Wrap from 0 is not used.
  - Beat with m_rlast: → IDLE, last <= grant.
  - The IDLE cycle gives 1 dead cycle between bursts.
- err_len:
  - Sets on a beat where m_rlast=1 and beats≠0.
  - Sets on a beat where m_rlast=0 and beats==0.
  - Cleared only by rst. Routing continues unaffected.
- No combinational path from s_* inputs to m_* outputs in IDLE. Zero-latency pass-through in ADDR and DATA.
- grant and busy are registered state.

Test Plan:
- Single request: s_arvalid=2'b01, araddr0=0x1000, arlen0=3, m_arready=1, 4 beats with rlast on the 4th → m_araddr=0x1000 one cycle after request; s_rvalid[0] pulses 4 times, s_rvalid[1] stays 0; FSM back to IDLE; grant=0; err_len=0.
- Simultaneous requests after reset: both arvalid, arlen=0 each → requester 0 served first, requester 1 second; exactly 1 IDLE cycle between m_rlast and the second m_arvalid.
- Fairness: both requesters assert continuously for 6 single-beat bursts → grant sequence 0,1,0,1,0,1.
- Backpressure: random m_arready/m_rvalid/s_rready at 50% on an arlen=7 burst → 8 beats delivered in order, data matches, no beat lost or duplicated, s_rid=captured arid.
- Length error: arlen=3, slave asserts rlast on beat 2 → err_len=1 from the next cycle and stays 1; FSM returns to IDLE; the next burst routes normally.
- Reset mid-burst: rst during beat 2 of arlen=7 → next cycle all valid/ready outputs 0, busy=0, err_len=0; a new request from requester 1 is granted first (last=1 → ~last=0 only if both are valid).
